// File: rtl/lzw_encode_ctrl.sv
// LZW encoder sequencer: tracks the prefix code, issues one CAM lookup/insert per byte, emits codes on a miss.
// Optional macro LZW_EOF_CODE_EN appends EOF_CODE as the final code of every stream.
module lzw_encode_ctrl #(
  parameter int unsigned LOGD       = 12,
  parameter int unsigned FIRST_CODE = 258,
  parameter int unsigned EOF_CODE   = 257
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGD-1:0] out_code,
  output logic            out_last,
  output logic            cam_fire,
  output logic [LOGD-1:0] cam_code,
  output logic [7:0]      cam_c,
  input  logic            cam_valid,
  input  logic [LOGD:0]   cam_encoding,
  output logic            dict_full
);

  localparam int unsigned CW = LOGD + 1;
  localparam logic [LOGD:0] FULL_CODE  = {1'b1, {LOGD{1'b0}}};
  localparam logic [LOGD:0] FIRST_C    = CW'(FIRST_CODE);

  // Reserved codes must sit below the first dynamic code, which must fit the dictionary.
  if ((EOF_CODE >= FIRST_CODE) || (FIRST_CODE >= (32'd1 << LOGD)) || (LOGD < 9)) begin : g_cfg_err
    $error("lzw_encode_ctrl: inconsistent LOGD/FIRST_CODE/EOF_CODE");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
`ifdef LZW_EOF_CODE_EN
    S_EOF   = 3'd6,
`endif
    S_FLUSH = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [LOGD-1:0] prefix_q, prefix_d;
  logic [7:0]      c_q, c_d;
  logic            last_q, last_d;
  logic [LOGD:0]   next_code_q, next_code_d;

  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [LOGD-1:0] out_code_q, out_code_d;
  logic            out_last_q, out_last_d;
  logic            cam_fire_q, cam_fire_d;
  logic [LOGD-1:0] cam_code_q, cam_code_d;
  logic [7:0]      cam_c_q, cam_c_d;
  logic            dict_full_q, dict_full_d;

  logic in_fire_c;
  logic out_fire_c;
  logic hit_c;

  assign in_fire_c  = in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready;
  // A full dictionary returns FULL_CODE, which equals next_code and so reads as a miss.
  assign hit_c      = (cam_encoding != next_code_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire_c) state_d = in_last ? S_FLUSH : S_READ;
      end
      S_READ: begin
        if (in_fire_c) state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cam_valid) begin
          if (hit_c) state_d = last_q ? S_FLUSH : S_READ;
          else       state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_fire_c) state_d = last_q ? S_FLUSH : S_READ;
      end
      S_FLUSH: begin
`ifdef LZW_EOF_CODE_EN
        if (out_fire_c) state_d = S_EOF;
`else
        if (out_fire_c) state_d = S_IDLE;
`endif
      end
`ifdef LZW_EOF_CODE_EN
      S_EOF: begin
        if (out_fire_c) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: prefix, pending byte, last flag, allocation counter
  always_comb begin
    prefix_d    = prefix_q;
    c_d         = c_q;
    last_d      = last_q;
    next_code_d = next_code_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire_c) prefix_d = LOGD'(in_byte);
      end
      S_READ: begin
        if (in_fire_c) begin
          c_d    = in_byte;
          last_d = in_last;
        end
      end
      S_WAIT: begin
        if (cam_valid) begin
          if (hit_c) begin
            prefix_d = cam_encoding[LOGD-1:0];
          end else if (next_code_q < FULL_CODE) begin
            next_code_d = next_code_q + CW'(1);
          end
        end
      end
      S_EMIT: begin
        if (out_fire_c) prefix_d = LOGD'(c_q);
      end
      default: begin
      end
    endcase
  end

  // Output logic: registered outputs follow the state being entered
  always_comb begin
    in_ready_d  = 1'b0;
    cam_fire_d  = 1'b0;
    cam_code_d  = cam_code_q;
    cam_c_d     = cam_c_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_code_d  = out_code_q;
    dict_full_d = (next_code_d == FULL_CODE);
    case (state_d)
      S_IDLE, S_READ: begin
        in_ready_d = 1'b1;
      end
      S_FIRE: begin
        cam_fire_d = 1'b1;
        cam_code_d = prefix_d;
        cam_c_d    = c_d;
      end
      S_EMIT: begin
        out_valid_d = 1'b1;
        out_code_d  = prefix_d;
      end
      S_FLUSH: begin
        out_valid_d = 1'b1;
        out_code_d  = prefix_d;
`ifdef LZW_EOF_CODE_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = 1'b1;
`endif
      end
`ifdef LZW_EOF_CODE_EN
      S_EOF: begin
        out_valid_d = 1'b1;
        out_code_d  = LOGD'(EOF_CODE);
        out_last_d  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  // Datapath and output registers; the dictionary counter only clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefix_q    <= '0;
      c_q         <= '0;
      last_q      <= 1'b0;
      next_code_q <= FIRST_C;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_last_q  <= 1'b0;
      cam_fire_q  <= 1'b0;
      cam_code_q  <= '0;
      cam_c_q     <= '0;
      dict_full_q <= 1'b0;
    end else begin
      prefix_q    <= prefix_d;
      c_q         <= c_d;
      last_q      <= last_d;
      next_code_q <= next_code_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_last_q  <= out_last_d;
      cam_fire_q  <= cam_fire_d;
      cam_code_q  <= cam_code_d;
      cam_c_q     <= cam_c_d;
      dict_full_q <= dict_full_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_last  = out_last_q;
  assign cam_fire  = cam_fire_q;
  assign cam_code  = cam_code_q;
  assign cam_c     = cam_c_q;
  assign dict_full = dict_full_q;

endmodule

// File: tb/tb_lzw_encode_ctrl.sv
// Directed bench for lzw_encode_ctrl (LOGD=9) with a behavioural 4-cycle dictionary CAM.
module tb_lzw_encode_ctrl;

  localparam int unsigned LOGD       = 9;
  localparam int unsigned FIRST_CODE = 258;
  localparam int unsigned FULL       = 512;
  localparam int unsigned BUDGET     = 200;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_byte;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [LOGD-1:0] out_code;
  logic            out_last;
  logic            cam_fire;
  logic [LOGD-1:0] cam_code;
  logic [7:0]      cam_c;
  logic            cam_valid;
  logic [LOGD:0]   cam_encoding;
  logic            dict_full;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned fire_cnt = 0;

  always #5 clk = ~clk;

  lzw_encode_ctrl #(.LOGD(LOGD), .FIRST_CODE(FIRST_CODE), .EOF_CODE(257)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_last     (out_last),
    .cam_fire     (cam_fire),
    .cam_code     (cam_code),
    .cam_c        (cam_c),
    .cam_valid    (cam_valid),
    .cam_encoding (cam_encoding),
    .dict_full    (dict_full)
  );

  // Dictionary CAM: lookup/insert on fire, result pulse 4 cycles later, cleared by rst
  int unsigned dict [int unsigned];
  int unsigned alloc;
  int unsigned key;
  logic          s1v, s2v, s3v;
  logic [LOGD:0] s1e, s2e, s3e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dict.delete();
      alloc = FIRST_CODE;
      s1v <= 1'b0; s2v <= 1'b0; s3v <= 1'b0;
      s1e <= '0;   s2e <= '0;   s3e <= '0;
      cam_valid    <= 1'b0;
      cam_encoding <= '0;
    end else begin
      s1v <= cam_fire;
      if (cam_fire) begin
        fire_cnt++;
        key = (32'(cam_code) << 8) | 32'(cam_c);
        if (dict.exists(key)) begin
          s1e <= (LOGD+1)'(dict[key]);
        end else if (alloc < FULL) begin
          dict[key] = alloc;
          s1e <= (LOGD+1)'(alloc);
          alloc++;
        end else begin
          s1e <= (LOGD+1)'(FULL);
        end
      end
      s2v <= s1v; s2e <= s1e;
      s3v <= s2v; s3e <= s2e;
      cam_valid    <= s3v;
      cam_encoding <= s3e;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
    bit done = 1'b0;
    in_valid = 1'b1; in_byte = b; in_last = last;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check({tag, " accepted"}, 32'(done), 32'd1);
  endtask

  task automatic recv_code(input logic [LOGD-1:0] exp_code, input logic exp_last, input string tag);
    bit done = 1'b0;
    logic [LOGD-1:0] code = '0;
    logic last = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        done = 1'b1; code = out_code; last = out_last;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check({tag, " out_valid seen"}, 32'(done), 32'd1);
    check({tag, " out_code"}, 32'(code), 32'(exp_code));
    check({tag, " out_last"}, 32'(last), 32'(exp_last));
  endtask

  task automatic expect_final(input logic [LOGD-1:0] exp_code, input string tag);
`ifdef LZW_EOF_CODE_EN
    recv_code(exp_code, 1'b0, tag);
    recv_code(9'h101, 1'b1, {tag, " eof"});
`else
    recv_code(exp_code, 1'b1, tag);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    logic [30:0] packed_outs;
    packed_outs = {in_ready, out_valid, out_last, cam_fire, out_code, cam_code, cam_c, dict_full};
    check(tag, 32'(packed_outs), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_all_zero(tag);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [11:0] hold_exp;
    logic [11:0] hold_obs;
    bit          seen;
    int unsigned f0;
    logic [7:0]  x, y;

    rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; out_ready = 1'b0;
    #12 check_all_zero("reset outputs");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle in_ready", 32'(in_ready), 32'd1);

    // Single byte: flushed directly, no CAM traffic
    f0 = fire_cnt;
    send_byte(8'h41, 1'b1, "t1 A");
    expect_final(9'h041, "t1 code");
    check("t1 no cam_fire", fire_cnt - f0, 32'd0);

    // "AB": miss on (A,B) allocates 258
    do_reset("t2 reset");
    send_byte(8'h41, 1'b0, "t2 A");
    send_byte(8'h42, 1'b1, "t2 B");
    recv_code(9'h041, 1'b0, "t2 code0");
    expect_final(9'h042, "t2 code1");
    // A CAM answer of 259 must read as a miss, so next_code must now be 259
    send_byte(8'h41, 1'b0, "t2b A");
    send_byte(8'h43, 1'b1, "t2b C");
    recv_code(9'h041, 1'b0, "t2b code0");
    expect_final(9'h043, "t2b code1");
    check("t2 dict_full", 32'(dict_full), 32'd0);

    // "AAA": miss then hit on code 258
    do_reset("t3 reset");
    send_byte(8'h41, 1'b0, "t3 A0");
    send_byte(8'h41, 1'b0, "t3 A1");
    recv_code(9'h041, 1'b0, "t3 code0");
    send_byte(8'h41, 1'b1, "t3 A2");
    expect_final(9'h102, "t3 code1");

    // Backpressure in EMIT for 10 cycles
    do_reset("t4 reset");
    send_byte(8'h41, 1'b0, "t4 A");
    send_byte(8'h42, 1'b1, "t4 B");
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("t4 emit reached", 32'(seen), 32'd1);
    f0 = fire_cnt;
    hold_exp = {1'b1, 1'b0, 1'b0, 9'h041};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hold_obs = {out_valid, out_last, in_ready, out_code};
      check("t4 hold", 32'(hold_obs), 32'(hold_exp));
    end
    check("t4 no extra fire", fire_cnt - f0, 32'd0);
    @(posedge clk); #1;
    recv_code(9'h041, 1'b0, "t4 code0");
    expect_final(9'h042, "t4 code1");

    // Reset while waiting for the CAM
    do_reset("t5 pre reset");
    send_byte(8'h41, 1'b0, "t5 A");
    send_byte(8'h42, 1'b1, "t5 B");
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_all_zero("t5 reset in wait");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("t5 no output after reset", 32'(out_valid), 32'd0);
    send_byte(8'h41, 1'b0, "t5 A2");
    send_byte(8'h42, 1'b1, "t5 B2");
    recv_code(9'h041, 1'b0, "t5 code0");
    expect_final(9'h042, "t5 code1");

    // 300 distinct pairs: dictionary fills at 512 and further misses still emit
    do_reset("t6 reset");
    for (int i = 0; i < 300; i++) begin
      x = 8'(i % 256);
      y = 8'(i / 256);
      send_byte(x, 1'b0, "t6 x");
      send_byte(y, 1'b1, "t6 y");
      recv_code(9'(x), 1'b0, "t6 code0");
      expect_final(9'(y), "t6 code1");
      check("t6 dict_full", 32'(dict_full), 32'(i + 1 >= 254));
    end
    send_byte(8'h00, 1'b0, "t6 hit 0");
    send_byte(8'h00, 1'b1, "t6 hit 1");
    expect_final(9'h102, "t6 hit code");
    send_byte(8'h50, 1'b0, "t6 new 0");
    send_byte(8'h60, 1'b1, "t6 new 1");
    recv_code(9'h050, 1'b0, "t6 full code0");
    expect_final(9'h060, "t6 full code1");
    check("t6 dict_full persists", 32'(dict_full), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lzw_encode_ctrl.md
Name: lzw_encode_ctrl

Overview:
Sequencer for the LZW dictionary CAM. It accepts a byte stream and holds the current prefix code. For each new byte it issues one CAM lookup/insert, then either extends the prefix (hit) or emits the prefix as an output code (miss). It sits between the RoCC byte-fetch stage and the code packer, and it owns the CAM's fire/code/c inputs.

Parameters:
LOGD, 12, log2 of dictionary depth; must match the CAM's logd
FIRST_CODE, 258, first dynamically allocated dictionary code; codes 256/257 are reserved
EOF_CODE, 257, reserved end-of-stream code (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input byte valid
in_ready  out  1  controller accepts a byte this cycle
in_byte  in  8  input byte
in_last  in  1  byte is the final byte of the stream
out_valid  out  1  output code valid
out_ready  in  1  downstream accepts the code
out_code  out  LOGD  emitted LZW code
out_last  out  1  final code of the stream
cam_fire  out  1  single-cycle CAM request
cam_code  out  LOGD  prefix code to CAM
cam_c  out  8  appended byte to CAM
cam_valid  in  1  CAM result pulse
cam_encoding  in  LOGD+1  CAM result code
dict_full  out  1  next_code has reached 2**LOGD

Behaviour:
- Reset (async assert, while rst high): state=IDLE; in_ready, out_valid, out_last, cam_fire = 0; out_code, cam_code, cam_c = 0; prefix=0; next_code=FIRST_CODE; dict_full=0. Reset mid-operation aborts the transfer without emitting anything. The CAM shares rst.
- Registered state: prefix[LOGD-1:0], c_q[7:0], last_q, next_code[LOGD:0].
- IDLE: in_ready=1. On accept: prefix<=in_byte. If in_last, go FLUSH; otherwise go READ.
- READ: in_ready=1. On accept: c_q<=in_byte, last_q<=in_last, go FIRE.
- FIRE: cam_fire=1 for exactly one cycle; cam_code=prefix, cam_c=c_q. Go WAIT. cam_code/cam_c are held stable until cam_valid.
- WAIT: in_ready=0. The CAM returns cam_valid 4 cycles after fire; the controller waits for it without a timeout.
  - Hit (cam_encoding != next_code): prefix<=cam_encoding[LOGD-1:0]. If last_q, go FLUSH; otherwise go READ.
  - Miss (cam_encoding == next_code): out_code<=prefix, go EMIT. If next_code < 2**LOGD, next_code++.
  - Full dictionary: the CAM returns encoding=2**LOGD, which equals next_code. This is treated as a miss, with no increment.
- EMIT: out_valid=1, out_last=0. out_code holds until out_ready. On the handshake: prefix<=c_q; if last_q, go FLUSH; otherwise go READ.
- FLUSH: out_valid=1, out_code=prefix, out_last=1. On the handshake, go IDLE.
- out_valid/out_code/out_last are registered and stable while out_valid && !out_ready.
- in_ready is 0 in FIRE, WAIT, EMIT and FLUSH. It is never combinationally dependent on out_ready.
- dict_full = (next_code == 2**LOGD). It persists until rst, because dictionary contents persist across streams.
- Throughput: one byte per 6 cycles minimum on a hit (READ, FIRE, 4 cycles in WAIT). A miss adds EMIT plus any backpressure.

Optional Feature:
Macro LZW_EOF_CODE_EN.
- Defined: FLUSH emits the prefix with out_last=0, then enters state EOF. EOF drives out_code=EOF_CODE and out_last=1; on the handshake it goes IDLE.
- Undefined: no EOF state; FLUSH carries out_last=1 and the stream ends there.

Test Plan:
- Single byte 0x41 with last -> one code 0x041 with out_last=1; cam_fire never asserted.
- Bytes 0x41,0x42(last) -> CAM miss returns 258; outputs 0x041 (last=0) then 0x042 (last=1); next_code=259.
- Bytes 0x41,0x41,0x41(last) -> first lookup misses (258), second hits (258); outputs 0x041 then 0x102 with last=1; next_code=259.
- out_ready held low 10 cycles during EMIT -> out_valid/out_code stable, in_ready=0, no extra cam_fire.
- LOGD=9, stream of 300 distinct byte pairs -> next_code saturates at 512, dict_full=1, subsequent misses still emit prefix codes and next_code does not wrap.
- rst asserted in WAIT -> all outputs 0 the same cycle; next stream "AB" after deassert yields 0x041, 0x042. With LZW_EOF_CODE_EN, the same stream ends with 0x101, last=1.
